edram_rr_scheduler: RTL and testbench



---
 rtl/edram_rr_scheduler_if.sv | 32 +++
 rtl/edram_rr_scheduler.sv | 167 ++++++++++++++++
 tb/tb_edram_rr_scheduler.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/edram_rr_scheduler_if.sv
// Bundled requester and eDRAM-side signals for edram_rr_scheduler.
// The slave modport is the scheduler; the master modport is the requesters plus the eDRAM macro.
interface edram_rr_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 4
);
   logic [NUM_REQ-1:0]            req_ren;
   logic [NUM_REQ-1:0]            req_wen;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ*CNT_WIDTH-1:0]  req_wcnt;
   logic [NUM_REQ-1:0]            req_ack;
   logic [DATA_WIDTH-1:0]         req_rdata;
   logic                          ram_ren;
   logic                          ram_wen;
   logic [ADDR_WIDTH-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0]         ram_wdata;
   logic [DATA_WIDTH-1:0]         ram_rdata;
   logic                          busy;

   modport slave (
      input  req_ren, req_wen, req_addr, req_wdata, req_wcnt, ram_rdata,
      output req_ack, req_rdata, ram_ren, ram_wen, ram_addr, ram_wdata, busy
   );

   modport master (
      output req_ren, req_wen, req_addr, req_wdata, req_wcnt, ram_rdata,
      input  req_ack, req_rdata, ram_ren, ram_wen, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/edram_rr_scheduler.sv
// Round-robin eDRAM port scheduler with a per-entry consumer-count file.
// Optional macro EDRAM_SCHED_WRITE_PRIO_EN: eligible writes win over eligible reads.
//
// state | meaning
// IDLE  | arbitrate among eligible requesters, latch winner, update count
// BUSY  | drive eDRAM for MEM_LAT cycles, capture read data on the last one
// DONE  | one-cycle ack to the winner, record it as last grant
module edram_rr_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 4,
   parameter int MEM_LAT    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   edram_rr_scheduler_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(MEM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  op_wr_q, op_wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [IDX_W-1:0]      last_grant_q, last_grant_d;
   logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
   logic [CNT_WIDTH-1:0]  cnt_q [DEPTH];
   logic [CNT_WIDTH-1:0]  cnt_d [DEPTH];

   logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
   logic [CNT_WIDTH-1:0]  wcnt_a  [NUM_REQ];

   logic [NUM_REQ-1:0]    rd_elig;
   logic [NUM_REQ-1:0]    wr_elig;
   logic [NUM_REQ-1:0]    cand;
   logic                  found;
   logic [IDX_W-1:0]      pick;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_a[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
      assign wcnt_a[g]  = bus.req_wcnt[g*CNT_WIDTH +: CNT_WIDTH];
   end

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // A read takes precedence when both enables are set, so a write needs ren low.
   always_comb begin
      rd_elig = '0;
      wr_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rd_elig[i] = bus.req_ren[i] & (cnt_q[addr_a[i]] != '0);
         wr_elig[i] = bus.req_wen[i] & ~bus.req_ren[i] & (cnt_q[addr_a[i]] == '0);
      end
   end

`ifdef EDRAM_SCHED_WRITE_PRIO_EN
   assign cand = (|wr_elig) ? wr_elig : rd_elig;
`else
   assign cand = rd_elig | wr_elig;
`endif

   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && cand[rr_idx(last_grant_q, k)]) begin
            found = 1'b1;
            pick  = rr_idx(last_grant_q, k);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      op_wr_d      = op_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      last_grant_d = last_grant_q;
      lat_cnt_d    = lat_cnt_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               idx_d     = pick;
               op_wr_d   = ~bus.req_ren[pick];
               addr_d    = addr_a[pick];
               wdata_d   = wdata_a[pick];
               rdata_d   = '0;
               lat_cnt_d = '0;
               state_d   = S_BUSY;
               // Count moves at grant so the next arbitration already sees it.
               if (!bus.req_ren[pick]) begin
                  cnt_d[addr_a[pick]] = (wcnt_a[pick] == '0) ? CNT_WIDTH'(1) : wcnt_a[pick];
               end else begin
                  cnt_d[addr_a[pick]] = cnt_q[addr_a[pick]] - CNT_WIDTH'(1);
               end
            end
         end
         S_BUSY: begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
            if (lat_cnt_q == LAT_END) begin
               if (!op_wr_q) rdata_d = bus.ram_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            last_grant_d = idx_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         op_wr_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         last_grant_q <= LAST_IDX;
         lat_cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         op_wr_q      <= op_wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         last_grant_q <= last_grant_d;
         lat_cnt_q    <= lat_cnt_d;
         cnt_q        <= cnt_d;
      end
   end

   // Outputs decode from state alone, so an async reset clears them at once.
   assign bus.ram_ren   = (state_q == S_BUSY) & ~op_wr_q;
   assign bus.ram_wen   = (state_q == S_BUSY) & op_wr_q;
   assign bus.ram_addr  = (state_q == S_BUSY) ? addr_q : '0;
   assign bus.ram_wdata = ((state_q == S_BUSY) && op_wr_q) ? wdata_q : '0;
   assign bus.req_ack   = (state_q == S_DONE) ? (NUM_REQ'(1) << idx_q) : '0;
   assign bus.req_rdata = ((state_q == S_DONE) && !op_wr_q) ? rdata_q : '0;
   assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_edram_rr_scheduler.sv
// Directed bench for edram_rr_scheduler: requesters and eDRAM model driven from one initial block.
module tb_edram_rr_scheduler;
   localparam int NR  = 4;
   localparam int AW  = 6;
   localparam int DW  = 16;
   localparam int CW  = 4;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   edram_rr_scheduler_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   edram_rr_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] mem [64];
   always @(posedge clk) if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
   assign bus.ram_rdata = bus.ram_ren ? mem[bus.ram_addr] : '0;

   int n_cmp = 0;
   int n_bad = 0;
   int n_ren = 0;
   int n_ack = 0;
   int ren0, ack0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; observe at the falling edge, and drop any acked request there.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (bus.ram_ren) n_ren++;
      if (bus.req_ack != '0) begin
         n_ack++;
         bus.req_ren = bus.req_ren & ~bus.req_ack;
         bus.req_wen = bus.req_wen & ~bus.req_ack;
      end
   endtask

   task automatic set_req(input int i, input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [CW-1:0] c);
      bus.req_ren[i]            = r;
      bus.req_wen[i]            = w;
      bus.req_addr[i*AW +: AW]  = a;
      bus.req_wdata[i*DW +: DW] = d;
      bus.req_wcnt[i*CW +: CW]  = c;
   endtask

   task automatic wait_ack(input string tag, input int who, input int exp_lat, input logic [DW-1:0] exp_rd);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 40) begin
         tick();
         n++;
         hit = bus.req_ack[who];
      end
      check({tag, "_lat"}, hit ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
      check({tag, "_ack"}, 32'(bus.req_ack), 32'(1 << who));
      check({tag, "_rdata"}, 32'(bus.req_rdata), 32'(exp_rd));
   endtask

   initial begin
      rst           = 1'b1;
      bus.req_ren   = '0;
      bus.req_wen   = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wcnt  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_ack", 32'(bus.req_ack), 0);
      check("rst_ren", 32'(bus.ram_ren), 0);
      check("rst_wen", 32'(bus.ram_wen), 0);
      check("rst_rdata", 32'(bus.req_rdata), 0);
      check("rst_cnt5", 32'(dut.cnt_q[5]), 0);

      // Write by req 2: three eDRAM write cycles, ack on the fourth.
      set_req(2, 0, 1, 6'd5, 16'hBEEF, 4'd2);
      for (int k = 0; k < LAT; k++) begin
         tick();
         check($sformatf("w2_wen%0d", k), 32'(bus.ram_wen), 1);
         check($sformatf("w2_addr%0d", k), 32'(bus.ram_addr), 5);
         check($sformatf("w2_wdata%0d", k), 32'(bus.ram_wdata), 32'hBEEF);
      end
      tick();
      check("w2_ack", 32'(bus.req_ack), 32'b0100);
      check("w2_ack_rdata", 32'(bus.req_rdata), 0);
      check("w2_done_wen", 32'(bus.ram_wen), 0);
      check("w2_cnt5", 32'(dut.cnt_q[5]), 2);
      tick();
      check("w2_idle", 32'(bus.busy), 0);

      // Two readers of the same entry, served one at a time starting with req 0.
      set_req(0, 1, 0, 6'd5, 16'h0, 4'd0);
      set_req(1, 1, 0, 6'd5, 16'h0, 4'd0);
      wait_ack("rd0", 0, 4, 16'hBEEF);
      wait_ack("rd1", 1, 5, 16'hBEEF);
      check("rd_cnt5", 32'(dut.cnt_q[5]), 0);
      tick();

      // Third reader stalls on the drained entry until it is rewritten.
      set_req(3, 1, 0, 6'd5, 16'h0, 4'd0);
      ren0 = n_ren;
      ack0 = n_ack;
      repeat (10) tick();
      check("stall3_ren", 32'(n_ren - ren0), 0);
      check("stall3_ack", 32'(n_ack - ack0), 0);
      set_req(2, 0, 1, 6'd5, 16'h1234, 4'd1);
      wait_ack("rw2", 2, 4, 16'h0);
      wait_ack("rd3", 3, 5, 16'h1234);
      tick();

      // All four write at once: grants 0,1,2,3; then a read round restarts at 0.
      for (int i = 0; i < NR; i++) set_req(i, 0, 1, 6'(10 + i), 16'(16'hA000 + i), 4'd1);
      for (int i = 0; i < NR; i++) wait_ack($sformatf("wall%0d", i), i, (i == 0) ? 4 : 5, 16'h0);
      tick();
      for (int i = 0; i < NR; i++) set_req(i, 1, 0, 6'(10 + i), 16'h0, 4'd0);
      for (int i = 0; i < NR; i++) wait_ack($sformatf("rall%0d", i), i, (i == 0) ? 4 : 5, 16'(16'hA000 + i));
      tick();

      // Read of an empty entry waits; a write with wcnt 0 lets exactly one read through.
      set_req(0, 1, 0, 6'd7, 16'h0, 4'd0);
      ren0 = n_ren;
      ack0 = n_ack;
      repeat (20) tick();
      check("empty7_ren", 32'(n_ren - ren0), 0);
      check("empty7_ack", 32'(n_ack - ack0), 0);
      check("empty7_busy", 32'(bus.busy), 0);
      set_req(1, 0, 1, 6'd7, 16'h7777, 4'd0);
      wait_ack("w7", 1, 4, 16'h0);
      wait_ack("r7", 0, 5, 16'h7777);
      check("cnt7", 32'(dut.cnt_q[7]), 0);
      tick();

      // Reset during the second BUSY cycle of a write.
      set_req(2, 0, 1, 6'd20, 16'h5555, 4'd3);
      tick();
      tick();
      check("mid_busy", 32'(bus.busy), 1);
      check("mid_cnt20", 32'(dut.cnt_q[20]), 3);
      rst = 1'b1;
      #1;
      check("mid_rst_wen", 32'(bus.ram_wen), 0);
      check("mid_rst_addr", 32'(bus.ram_addr), 0);
      check("mid_rst_busy", 32'(bus.busy), 0);
      bus.req_ren = '0;
      bus.req_wen = '0;
      ack0 = n_ack;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      check("mid_no_ack", 32'(n_ack - ack0), 0);
      check("mid_cnt20_clr", 32'(dut.cnt_q[20]), 0);

      // Read vs write contention with write priority optional.
      set_req(3, 0, 1, 6'd1, 16'h1111, 4'd1);
      wait_ack("w1", 3, 4, 16'h0);
      tick();
      set_req(0, 1, 0, 6'd1, 16'h0, 4'd0);
      set_req(3, 0, 1, 6'd2, 16'h2222, 4'd1);
`ifdef EDRAM_SCHED_WRITE_PRIO_EN
      wait_ack("prio_w3", 3, 4, 16'h0);
      wait_ack("prio_r0", 0, 5, 16'h1111);
`else
      wait_ack("prio_r0", 0, 4, 16'h1111);
      wait_ack("prio_w3", 3, 5, 16'h0);
`endif
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
